// File: rtl/mont_seq_ctrl_if.sv
// Operand buses, phase/enable strobes and status flags between the Montgomery sequencer and mpadder.
interface mont_seq_ctrl_if;
    logic         cZero;
    logic         cOne;
    logic         carry;
    logic         adder_rst_n;
    logic [511:0] B0;
    logic [512:0] B1;
    logic [511:0] M0;
    logic [512:0] M1;
    logic [513:0] subtraction;
    logic         c_doubleshift;
    logic         enableC;
    logic [3:0]   showFluffyPonies;
    logic         subtract;

    modport master (
        input  cZero, cOne, carry,
        output adder_rst_n, B0, B1, M0, M1, subtraction,
               c_doubleshift, enableC, showFluffyPonies, subtract
    );

    modport slave (
        output cZero, cOne, carry,
        input  adder_rst_n, B0, B1, M0, M1, subtraction,
               c_doubleshift, enableC, showFluffyPonies, subtract
    );
endinterface

// File: rtl/mont_seq_ctrl.sv
// Radix-4 Montgomery product sequencer (R = A*B*2^-512 mod M) driving mpadder's buses and strobes.
// Latency: done 521+6p cycles after start (p = subtract passes); start is ignored unless idle.
module mont_seq_ctrl #(
    parameter int N_DIGITS = 256,
    parameter int MAX_SUB  = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [511:0]    a_in,
    input  logic [511:0]    b_in,
    input  logic [511:0]    m_in,
    output logic            busy,
    output logic            done,
    output logic            err,
    mont_seq_ctrl_if.master adder
);
    typedef enum logic [2:0] {IDLE, INIT, SEL, STEP, ADDP, HOLD, SUBP, DONE} state_t;

    state_t       state;
    logic [511:0] regA;
    logic [511:0] regB;
    logic [511:0] regM;
    logic [7:0]   k;
    logic [2:0]   phase;
    logic [7:0]   passCnt;

    logic [1:0]   dig;
    logic [1:0]   dbLow;
    logic [1:0]   tSum;
    logic [1:0]   qDig;

    // q makes the low two bits of C + d*B + q*M zero; -M^-1 mod 4 is 1 when M[1] is set, else 3.
    always_comb begin
        dig   = regA[{k, 1'b0} +: 2];
        dbLow = dig * regB[1:0];
        tSum  = {adder.cOne, adder.cZero} + dbLow;
        qDig  = regM[1] ? tSum : 2'(2'd0 - tSum);
    end

    assign adder.enableC = 1'b0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state                  <= IDLE;
            regA                   <= '0;
            regB                   <= '0;
            regM                   <= '0;
            k                      <= '0;
            phase                  <= '0;
            passCnt                <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            err                    <= 1'b0;
            adder.adder_rst_n      <= 1'b1;
            adder.B0               <= '0;
            adder.B1               <= '0;
            adder.M0               <= '0;
            adder.M1               <= '0;
            adder.subtraction      <= '0;
            adder.c_doubleshift    <= 1'b0;
            adder.showFluffyPonies <= 4'd8;
            adder.subtract         <= 1'b0;
        end else begin
            done                <= 1'b0;
            adder.c_doubleshift <= 1'b0;
            adder.adder_rst_n   <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state             <= INIT;
                        busy              <= 1'b1;
                        adder.adder_rst_n <= 1'b0;
                    end
                end
                INIT: begin
                    regA              <= a_in;
                    regB              <= b_in;
                    regM              <= m_in;
                    adder.subtraction <= ~{1'b0, m_in, 1'b0};
                    k                 <= '0;
                    passCnt           <= '0;
                    err               <= 1'b0;
                    state             <= SEL;
                end
                SEL: begin
                    adder.B0            <= dig[0]  ? regB : '0;
                    adder.B1            <= dig[1]  ? {regB, 1'b0} : '0;
                    adder.M0            <= qDig[0] ? regM : '0;
                    adder.M1            <= qDig[1] ? {regM, 1'b0} : '0;
                    adder.c_doubleshift <= 1'b1;
                    state               <= STEP;
                end
                STEP: begin
                    if (k == 8'(N_DIGITS - 1)) begin
                        // Clear the operands so any stray shift strobe during the final add is harmless.
                        k                      <= '0;
                        phase                  <= '0;
                        adder.showFluffyPonies <= 4'd0;
                        adder.subtract         <= 1'b0;
                        adder.B0               <= '0;
                        adder.B1               <= '0;
                        adder.M0               <= '0;
                        adder.M1               <= '0;
                        state                  <= ADDP;
                    end else begin
                        k     <= k + 8'd1;
                        state <= SEL;
                    end
                end
                ADDP: begin
                    if (phase == 3'd5) begin
                        adder.showFluffyPonies <= 4'd8;
                        state                  <= HOLD;
                    end else begin
                        phase                  <= phase + 3'd1;
                        adder.showFluffyPonies <= {1'b0, phase + 3'd1};
                    end
                end
                HOLD: begin
                    phase                  <= '0;
                    adder.showFluffyPonies <= 4'd0;
                    adder.subtract         <= 1'b1;
                    state                  <= SUBP;
                end
                SUBP: begin
                    if (phase == 3'd5) begin
                        if (adder.carry || passCnt == 8'(MAX_SUB - 1)) begin
                            err                    <= ~adder.carry;
                            done                   <= 1'b1;
                            adder.showFluffyPonies <= 4'd8;
                            adder.subtract         <= 1'b0;
                            state                  <= DONE;
                        end else begin
                            passCnt                <= passCnt + 8'd1;
                            phase                  <= '0;
                            adder.showFluffyPonies <= 4'd0;
                        end
                    end else begin
                        phase                  <= phase + 3'd1;
                        adder.showFluffyPonies <= {1'b0, phase + 3'd1};
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
